// File: rtl/fuzz_wb_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fuzz_pkg                                                     |
// | Description : Shared types and constants for the fuzzing Wishbone arbiter. |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package fuzz_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RECOVER = 2'd2
    } arb_state_t;

    localparam int c_default_timeout_cycles = 100;

    localparam int c_master_monitor = 0;
    localparam int c_master_random  = 1;
    localparam int c_master_mutated = 2;

endpackage
`default_nettype wire

// File: rtl/rr_select.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rr_select                                                    |
// | Description : Combinational round-robin pick, searching from last+1.       |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module rr_select #(
    parameter int NUM_MASTERS = 3,
    parameter int IDX_W       = 2
) (
    input  logic [NUM_MASTERS-1:0] i_req,
    input  logic [IDX_W-1:0]       i_last_owner,
    output logic [NUM_MASTERS-1:0] o_grant
);

    logic [IDX_W-1:0] w_idx;

    // Walk from the farthest candidate to the nearest so the nearest requester wins.
    always_comb begin
        o_grant = '0;
        w_idx   = '0;
        for (int k = NUM_MASTERS; k >= 1; k--) begin
            w_idx = IDX_W'((int'(i_last_owner) + k) % NUM_MASTERS);
            if (i_req[w_idx]) begin
                o_grant        = '0;
                o_grant[w_idx] = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fuzz_wb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fuzz_wb_arbiter                                              |
// | Description : Round-robin Wishbone arbiter with bus-lock and slave timeout.|
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module fuzz_wb_arbiter
    import fuzz_pkg::*;
#(
    parameter int NUM_MASTERS     = 3,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int READ_DATA_WIDTH = 64,
    parameter int TIMEOUT_CYCLES  = c_default_timeout_cycles
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [NUM_MASTERS-1:0]                m_cyc,
    input  logic [NUM_MASTERS-1:0]                m_stb,
    input  logic [NUM_MASTERS-1:0]                m_we,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]     m_adr,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0]     m_dat,
    input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0]   m_sel,
    output logic [NUM_MASTERS-1:0]                m_ack,
    output logic [NUM_MASTERS-1:0]                m_err,
    output logic [READ_DATA_WIDTH-1:0]            m_dat_o,
    output logic                                  s_cyc,
    output logic                                  s_stb,
    output logic                                  s_we,
    output logic [ADDR_WIDTH-1:0]                 s_adr,
    output logic [DATA_WIDTH-1:0]                 s_dat,
    output logic [DATA_WIDTH/8-1:0]               s_sel,
    input  logic                                  s_ack,
    input  logic                                  s_err,
    input  logic [READ_DATA_WIDTH-1:0]            s_dat_o,
    input  logic [NUM_MASTERS-1:0]                req_mask,
    output logic [NUM_MASTERS-1:0]                grant,
    output logic                                  timeout_evt,
    output logic [1:0]                            timeout_id,
    output logic [NUM_MASTERS*16-1:0]             xfer_cnt
);

    localparam int c_idx_w  = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int c_sel_w  = DATA_WIDTH / 8;
    localparam int c_wait_w = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_wait_w-1:0] c_wait_limit = c_wait_w'(TIMEOUT_CYCLES - 1);
    localparam logic [c_idx_w-1:0]  c_last_rst   = c_idx_w'(NUM_MASTERS - 1);

    arb_state_t             r_state;
    arb_state_t             w_state_nxt;
    logic [NUM_MASTERS-1:0] r_grant;
    logic [NUM_MASTERS-1:0] w_grant_nxt;
    logic [NUM_MASTERS-1:0] w_req;
    logic [NUM_MASTERS-1:0] w_rr_grant;
    logic [c_idx_w-1:0]     r_owner;
    logic [c_idx_w-1:0]     w_owner_nxt;
    logic [c_idx_w-1:0]     w_rr_idx;
    logic [c_wait_w-1:0]    r_wait;
    logic [1:0]             r_timeout_id;
    logic                   w_busy;
    logic                   w_own_cyc;
    logic                   w_own_stb;
    logic                   w_timeout;

    assign w_req = m_cyc & m_stb & req_mask;

    rr_select #(
        .NUM_MASTERS (NUM_MASTERS),
        .IDX_W       (c_idx_w)
    ) u_rr_select (
        .i_req        (w_req),
        .i_last_owner (r_owner),
        .o_grant      (w_rr_grant)
    );

    always_comb begin
        w_rr_idx = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (w_rr_grant[i]) begin
                w_rr_idx = c_idx_w'(i);
            end
        end
    end

    // r_owner doubles as last_owner once the bus is released.
    assign w_busy    = (r_state == BUSY);
    assign w_own_cyc = m_cyc[r_owner];
    assign w_own_stb = m_stb[r_owner];
    assign w_timeout = w_busy && w_own_cyc && w_own_stb && !s_ack && !s_err
                       && (r_wait == c_wait_limit);

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_owner_nxt = r_owner;
        case (r_state)
            IDLE: begin
                if (|w_req) begin
                    w_state_nxt = BUSY;
                    w_grant_nxt = w_rr_grant;
                    w_owner_nxt = w_rr_idx;
                end
            end
            BUSY: begin
                if (!w_own_cyc) begin
                    w_state_nxt = IDLE;
                    w_grant_nxt = '0;
                end else if (w_timeout) begin
                    w_state_nxt = RECOVER;
                    w_grant_nxt = '0;
                end
            end
            RECOVER: begin
                if (!w_own_cyc) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_grant      <= '0;
            r_owner      <= c_last_rst;
            r_wait       <= '0;
            r_timeout_id <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_owner <= w_owner_nxt;
            if (w_timeout) begin
                r_timeout_id <= 2'(r_owner);
            end
            if (!w_busy || s_ack || s_err || !w_own_stb) begin
                r_wait <= '0;
            end else if (r_wait != c_wait_limit) begin
                r_wait <= r_wait + c_wait_w'(1);
            end
        end
    end

    // Slave side sees the owner only while BUSY, so reset or RECOVER idles it at once.
    assign s_cyc = w_busy & w_own_cyc;
    assign s_stb = w_busy & w_own_stb;
    assign s_we  = w_busy & m_we[r_owner];
    assign s_adr = w_busy ? m_adr[int'(r_owner)*ADDR_WIDTH +: ADDR_WIDTH] : '0;
    assign s_dat = w_busy ? m_dat[int'(r_owner)*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign s_sel = w_busy ? m_sel[int'(r_owner)*c_sel_w +: c_sel_w] : '0;

    always_comb begin
        m_ack = '0;
        m_err = '0;
        if (w_busy) begin
            m_ack[r_owner] = s_ack;
            m_err[r_owner] = s_err | w_timeout;
        end
    end

    assign m_dat_o     = s_dat_o;
    assign grant       = r_grant;
    assign timeout_evt = w_timeout;
    assign timeout_id  = w_timeout ? 2'(r_owner) : r_timeout_id;

    generate
        for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_xfer_cnt
            logic [15:0] r_cnt;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_cnt <= '0;
                end else if (m_ack[gi] && (r_cnt != 16'hFFFF)) begin
                    r_cnt <= r_cnt + 16'd1;
                end
            end
            assign xfer_cnt[gi*16 +: 16] = r_cnt;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_fuzz_wb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_fuzz_wb_arbiter                                           |
// | Description : Directed vector bench for fuzz_wb_arbiter.                   |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_fuzz_wb_arbiter;
    import fuzz_pkg::*;

    localparam int NM = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int RW = 64;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NM-1:0]     m_cyc, m_stb, m_we, m_ack, m_err, req_mask, grant;
    logic [NM*AW-1:0]  m_adr;
    logic [NM*DW-1:0]  m_dat;
    logic [NM*DW/8-1:0] m_sel;
    logic [RW-1:0]     m_dat_o, s_dat_o;
    logic              s_cyc, s_stb, s_we, s_ack, s_err, timeout_evt;
    logic [AW-1:0]     s_adr;
    logic [DW-1:0]     s_dat;
    logic [DW/8-1:0]   s_sel;
    logic [1:0]        timeout_id;
    logic [NM*16-1:0]  xfer_cnt;

    fuzz_wb_arbiter #(
        .NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .READ_DATA_WIDTH(RW), .TIMEOUT_CYCLES(100)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr), .m_dat(m_dat),
        .m_sel(m_sel), .m_ack(m_ack), .m_err(m_err), .m_dat_o(m_dat_o),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_dat(s_dat),
        .s_sel(s_sel), .s_ack(s_ack), .s_err(s_err), .s_dat_o(s_dat_o),
        .req_mask(req_mask), .grant(grant), .timeout_evt(timeout_evt),
        .timeout_id(timeout_id), .xfer_cnt(xfer_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    typedef struct packed {
        logic [2:0] cyc;
        logic [2:0] stb;
        logic [2:0] mask;
        logic       ack;
        logic [2:0] exp_grant;
        logic       exp_scyc;
        logic [2:0] exp_mack;
    } vec_t;

    vec_t vecs [18];

    initial begin
        bit early;

        vecs[0]  = '{3'b110, 3'b110, 3'b111, 1'b0, 3'b000, 1'b0, 3'b000};
        vecs[1]  = '{3'b110, 3'b110, 3'b111, 1'b1, 3'b010, 1'b1, 3'b010};
        vecs[2]  = '{3'b100, 3'b100, 3'b111, 1'b0, 3'b010, 1'b0, 3'b000};
        vecs[3]  = '{3'b100, 3'b100, 3'b111, 1'b0, 3'b000, 1'b0, 3'b000};
        vecs[4]  = '{3'b100, 3'b100, 3'b111, 1'b1, 3'b100, 1'b1, 3'b100};
        vecs[5]  = '{3'b000, 3'b000, 3'b111, 1'b0, 3'b100, 1'b0, 3'b000};
        vecs[6]  = '{3'b100, 3'b100, 3'b011, 1'b0, 3'b000, 1'b0, 3'b000};
        vecs[7]  = '{3'b100, 3'b100, 3'b011, 1'b0, 3'b000, 1'b0, 3'b000};
        vecs[8]  = '{3'b100, 3'b100, 3'b111, 1'b0, 3'b000, 1'b0, 3'b000};
        vecs[9]  = '{3'b100, 3'b100, 3'b011, 1'b1, 3'b100, 1'b1, 3'b100};
        vecs[10] = '{3'b000, 3'b000, 3'b111, 1'b0, 3'b100, 1'b0, 3'b000};
        vecs[11] = '{3'b111, 3'b111, 3'b111, 1'b0, 3'b000, 1'b0, 3'b000};
        vecs[12] = '{3'b111, 3'b111, 3'b111, 1'b0, 3'b001, 1'b1, 3'b000};
        vecs[13] = '{3'b110, 3'b110, 3'b111, 1'b0, 3'b001, 1'b0, 3'b000};
        vecs[14] = '{3'b110, 3'b110, 3'b111, 1'b0, 3'b000, 1'b0, 3'b000};
        vecs[15] = '{3'b110, 3'b110, 3'b111, 1'b0, 3'b010, 1'b1, 3'b000};
        vecs[16] = '{3'b000, 3'b000, 3'b111, 1'b0, 3'b010, 1'b0, 3'b000};
        vecs[17] = '{3'b000, 3'b000, 3'b111, 1'b0, 3'b000, 1'b0, 3'b000};

        rst_n    = 1'b0;
        m_cyc    = '0;
        m_stb    = '0;
        m_we     = '0;
        m_adr    = {32'hC000_0002, 32'hB000_0001, 32'hA000_0000};
        m_dat    = {32'h2222_2222, 32'h1111_1111, 32'h0000_AAAA};
        m_sel    = 12'h731;
        req_mask = 3'b111;
        s_ack    = 1'b0;
        s_err    = 1'b0;
        s_dat_o  = 64'hDEAD_BEEF_0123_4567;

        // Reset state
        #3;
        check("rst grant", grant, 0);
        check("rst s_cyc", s_cyc, 0);
        check("rst s_stb", s_stb, 0);
        check("rst s_we", s_we, 0);
        check("rst m_ack", m_ack, 0);
        check("rst m_err", m_err, 0);
        check("rst timeout_evt", timeout_evt, 0);
        check("rst timeout_id", timeout_id, 0);
        check("rst xfer_cnt", xfer_cnt, 0);
        check("rst m_dat_o", m_dat_o, 64'hDEAD_BEEF_0123_4567);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Arbitration, masking and round-robin vectors
        for (int i = 0; i < 18; i++) begin
            m_cyc    = vecs[i].cyc;
            m_stb    = vecs[i].stb;
            req_mask = vecs[i].mask;
            s_ack    = vecs[i].ack;
            #1;
            check($sformatf("vec%0d grant", i), grant, vecs[i].exp_grant);
            check($sformatf("vec%0d s_cyc", i), s_cyc, vecs[i].exp_scyc);
            check($sformatf("vec%0d m_ack", i), m_ack, vecs[i].exp_mack);
            check($sformatf("vec%0d m_err", i), m_err, 0);
            tick();
        end
        s_ack    = 1'b0;
        req_mask = 3'b111;
        check("xfer after vectors", xfer_cnt, {16'd2, 16'd1, 16'd0});

        // Master 0 locked 4-beat burst while master 2 waits
        m_cyc = 3'b001; m_stb = 3'b001; m_we = 3'b001;
        #1;
        check("burst idle grant", grant, 0);
        tick();
        m_cyc = 3'b101; m_stb = 3'b101; s_ack = 1'b1;
        #1;
        check("burst s_adr", s_adr, 32'hA000_0000);
        check("burst s_dat", s_dat, 32'h0000_AAAA);
        check("burst s_sel", s_sel, 4'h1);
        check("burst s_we", s_we, 1);
        for (int b = 0; b < 4; b++) begin
            #1;
            check($sformatf("burst%0d grant", b), grant, 3'b001);
            check($sformatf("burst%0d m_ack", b), m_ack, 3'b001);
            tick();
        end
        m_cyc = 3'b100; m_stb = 3'b100; m_we = 3'b000; s_ack = 1'b0;
        #1;
        check("burst end s_cyc", s_cyc, 0);
        tick();
        check("burst gap grant", grant, 0);
        tick();
        check("burst m2 grant", grant, 3'b100);
        check("burst m2 s_adr", s_adr, 32'hC000_0002);
        check("burst xfer0", xfer_cnt[15:0], 16'd4);
        m_cyc = 3'b000; m_stb = 3'b000;
        tick();

        // Slave never acks master 1
        m_cyc = 3'b010; m_stb = 3'b010;
        tick();
        early = 1'b0;
        for (int n = 1; n < 100; n++) begin
            if (m_err !== 3'b000 || timeout_evt !== 1'b0) early = 1'b1;
            tick();
        end
        check("timeout early err", early, 0);
        check("timeout m_err", m_err, 3'b010);
        check("timeout evt", timeout_evt, 1);
        check("timeout id", timeout_id, 1);
        check("timeout m_ack", m_ack, 0);
        m_cyc = 3'b110; m_stb = 3'b110;
        tick();
        check("recover s_cyc", s_cyc, 0);
        check("recover s_stb", s_stb, 0);
        check("recover grant", grant, 0);
        check("recover evt", timeout_evt, 0);
        check("recover id", timeout_id, 1);
        tick();
        check("recover hold grant", grant, 0);
        m_cyc = 3'b100; m_stb = 3'b100;
        tick();
        check("recover exit grant", grant, 0);
        tick();
        check("post recover grant", grant, 3'b100);
        m_cyc = 3'b000; m_stb = 3'b000;
        tick();

        // Ack coincides with the timeout threshold
        m_cyc = 3'b001; m_stb = 3'b001;
        tick();
        for (int n = 1; n < 100; n++) tick();
        s_ack = 1'b1;
        #1;
        check("ackwin m_ack", m_ack, 3'b001);
        check("ackwin m_err", m_err, 0);
        check("ackwin evt", timeout_evt, 0);
        tick();
        s_ack = 1'b0;
        #1;
        check("ackwin hold s_cyc", s_cyc, 1);
        check("ackwin hold grant", grant, 3'b001);
        check("ackwin no evt", timeout_evt, 0);
        check("ackwin xfer0", xfer_cnt[15:0], 16'd5);
        m_cyc = 3'b000; m_stb = 3'b000;
        tick();

        // Reset mid-write
        s_dat_o = 64'h0123_4567_89AB_CDEF;
        m_cyc = 3'b010; m_stb = 3'b010; m_we = 3'b010;
        tick();
        check("rstmid pre s_cyc", s_cyc, 1);
        check("rstmid pre s_we", s_we, 1);
        check("rstmid m_dat_o", m_dat_o, 64'h0123_4567_89AB_CDEF);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstmid s_cyc", s_cyc, 0);
        check("rstmid grant", grant, 0);
        s_ack = 1'b1;
        #1;
        check("rstmid m_ack", m_ack, 0);
        check("rstmid m_err", m_err, 0);
        check("rstmid xfer", xfer_cnt, 0);
        s_ack = 1'b0;
        m_cyc = 3'b111; m_stb = 3'b111; m_we = 3'b000;
        tick();
        rst_n = 1'b1;
        #1;
        check("rstmid idle grant", grant, 0);
        tick();
        check("rstmid first grant", grant, 3'b001);
        m_cyc = 3'b000; m_stb = 3'b000;
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fuzz_wb_arbiter.md
FUZZ_WB_ARBITER -- requirements
Module: fuzz_wb_arbiter

Interface
REQ-001 Parameters (name, default, meaning), one per line, SHALL be:
  NUM_MASTERS      3     Wishbone requesters sharing the DUT slave port (index 0 = SoC monitor path, 1 = random fuzzer, 2 = mutated fuzzer)
  ADDR_WIDTH       32    address width
  DATA_WIDTH       32    write-data width
  READ_DATA_WIDTH  64    slave read-data width
  TIMEOUT_CYCLES   100   cycles with stb high and no ack/err before forced error
REQ-002 Ports (name, direction, width, meaning), one per line, SHALL be:
  clk          in   1                      single clock
  rst_n        in   1                      asynchronous active-low reset
  m_cyc        in   NUM_MASTERS            per-master cycle
  m_stb        in   NUM_MASTERS            per-master strobe
  m_we         in   NUM_MASTERS            per-master write enable
  m_adr        in   NUM_MASTERS*ADDR_WIDTH packed addresses, master i at [i*ADDR_WIDTH +: ADDR_WIDTH]
  m_dat        in   NUM_MASTERS*DATA_WIDTH packed write data
  m_sel        in   NUM_MASTERS*DATA_WIDTH/8 packed byte selects
  m_ack        out  NUM_MASTERS            per-master ack
  m_err        out  NUM_MASTERS            per-master error
  m_dat_o      out  READ_DATA_WIDTH        slave read data, broadcast to all masters
  s_cyc, s_stb, s_we  out  1               slave controls
  s_adr        out  ADDR_WIDTH             slave address
  s_dat        out  DATA_WIDTH             slave write data
  s_sel        out  DATA_WIDTH/8           slave byte selects
  s_ack, s_err in   1                      slave responses
  s_dat_o      in   READ_DATA_WIDTH        slave read data
  req_mask     in   NUM_MASTERS            1 = master may be granted
  grant        out  NUM_MASTERS            one-hot current owner, 0 when idle
  timeout_evt  out  1                      one-cycle pulse on forced timeout
  timeout_id   out  2                      index of the last master timed out
  xfer_cnt     out  NUM_MASTERS*16         per-master completed-ack counters, saturating

Function
REQ-003 FSM states SHALL be IDLE, BUSY and RECOVER.
REQ-004 A request SHALL be m_cyc[i] & m_stb[i] & req_mask[i]; IDLE->BUSY on any request, with grant registered, so s_cyc rises one cycle after the request.
REQ-005 Arbitration SHALL be round-robin: search starts at last_owner+1 (mod NUM_MASTERS), so master 0 is searched first after reset.
REQ-006 In BUSY, s_* SHALL mirror the owner's inputs combinationally; s_ack/s_err SHALL route only to the owner; the other masters SHALL see ack = err = 0.
REQ-007 m_dat_o SHALL equal s_dat_o at all times.
REQ-008 The owner SHALL keep the bus while its m_cyc is high, so bursts are locked; BUSY->IDLE when the owner's m_cyc falls, and the next grant follows no earlier than the following cycle.
REQ-009 Deasserting req_mask during BUSY SHALL NOT abort the owner; the mask is sampled only at arbitration.
REQ-010 The wait counter SHALL clear on s_ack, s_err or a stb low cycle, and increment otherwise while in BUSY.
REQ-011 When the wait counter reaches TIMEOUT_CYCLES-1, the arbiter SHALL drive m_err[owner] for one cycle, pulse timeout_evt, latch timeout_id, force s_cyc/s_stb low and enter RECOVER.
REQ-012 RECOVER SHALL hold the slave idle and all grants 0 until the timed-out master drops m_cyc, then go to IDLE.
REQ-013 If s_ack and the timeout fire in the same cycle, the ack SHALL win: no error and no timeout_evt.
REQ-014 xfer_cnt[i] SHALL increment on each ack forwarded to master i and saturate at 16'hFFFF; errors are not counted.

Reset
REQ-015 With rst_n low, the block SHALL hold state=IDLE, last_owner=NUM_MASTERS-1, grant=0, s_cyc=s_stb=s_we=0, all m_ack/m_err=0, timeout_evt=0, timeout_id=0, wait counter=0 and all xfer_cnt=0.
REQ-016 Reset asserted mid-transaction SHALL immediately release the slave (s_cyc=0) with no ack or err issued.

Structure
REQ-017 The FSM state enum, the default TIMEOUT_CYCLES and the master-index constants SHALL live in package fuzz_pkg.
REQ-018 Round-robin selection SHALL be a sub-module rr_select (request vector, last owner -> one-hot grant, pure combinational).

Verification
REQ-019 The bench SHALL cover these directed scenarios:
  - Masters 1 and 2 request together after reset -> master 1 granted first, master 2 granted after master 1 drops cyc.
  - Master 0 holds cyc for a 4-beat burst while master 2 requests -> master 2 waits, grant=3'b100 only after the burst.
  - Slave never acks master 1 -> m_err[1] in the 100th stb cycle, timeout_evt=1, timeout_id=1, s_cyc=0 next cycle.
  - s_ack arrives in the same cycle as the timeout threshold -> ack delivered, no timeout_evt.
  - req_mask=3'b011 with only master 2 requesting -> grant stays 0; set the mask -> granted next cycle.
  - rst_n pulsed low mid-write -> s_cyc=0 asynchronously, xfer_cnt cleared, and the first grant after reset goes to master 0.
